// File: rtl/slope_pkg.sv
// Shared types and constants for slope_period_meter.
package slope_pkg;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} spm_state_t;

  typedef enum logic {EXT_MAX = 1'b0, EXT_MIN = 1'b1} ext_mode_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH = 24;

  // Saturation ceiling; each instance keeps the low CNT_WIDTH bits.
  localparam logic [63:0] CNT_MAX = '1;

  // Record layout at the default widths, for downstream consumers.
  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0] period;
    logic [DEF_WIDTH-1:0]     peak;
    logic [DEF_WIDTH-1:0]     valley;
    logic                     period_sat;
  } spm_rec_t;

endpackage

// File: rtl/extremum_track.sv
// Running max or min of a sample stream. ext is the extremum including the
// current sample; restart reloads the tracker with the current sample.
module extremum_track
  import slope_pkg::*;
#(
  parameter int        WIDTH = DEF_WIDTH,
  parameter ext_mode_t MODE  = EXT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             restart,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] ext
);

  localparam logic [WIDTH-1:0] INIT = (MODE == EXT_MAX) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

  logic [WIDTH-1:0] run;

  // Extremum of the stored run and the sample arriving this cycle.
  always_comb begin
    if (MODE == EXT_MAX) ext = (datain > run) ? datain : run;
    else                 ext = (datain < run) ? datain : run;
  end

  // Hold the running extremum, or restart it at the current sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       run <= INIT;
    else if (clr)     run <= INIT;
    else if (restart) run <= datain;
    else              run <= ext;
  end

endmodule

// File: rtl/slope_period_meter.sv
// slope_period_meter: turns slope-detector peak/valley pulses into one
// {period, peak, valley} record per peak over a valid/ready handshake.
// Optional build macro SPM_HYST_EN: peaks whose swing above the last valley
// is below HYST are treated as noise and ignored.
module slope_period_meter
  import slope_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int HYST      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     datain,
  input  logic                 posen,
  input  logic                 negen,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] period,
  output logic [WIDTH-1:0]     peak,
  output logic [WIDTH-1:0]     valley,
  output logic                 period_sat,
  output logic                 overrun
);

  localparam logic [CNT_WIDTH-1:0] CNT_TOP = CNT_MAX[CNT_WIDTH-1:0];
`ifdef SPM_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif
  localparam logic [WIDTH:0] HYST_V = (WIDTH+1)'(HYST);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] period;
    logic [WIDTH-1:0]     peak;
    logic [WIDTH-1:0]     valley;
    logic                 period_sat;
  } rec_t;

  spm_state_t           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sat_q;
  logic [WIDTH-1:0]     valley_q;
  logic                 valley_seen;
  logic [WIDTH-1:0]     max_now, min_now;
  logic [WIDTH:0]       swing;
  logic                 neg_ev, noise, arm, rec_fire, min_restart;
  rec_t                 rec_new, rec_q;

  // A valley pulse coinciding with a peak pulse is dropped; the peak wins.
  assign neg_ev = negen & ~posen;

  // Swing in WIDTH+1 bits so a peak below the valley reads as a borrow, not a wrap.
  assign swing = {1'b0, max_now} - {1'b0, valley_q};
  assign noise = HYST_ON && (state == ARMED) && valley_seen && (swing[WIDTH] || (swing < HYST_V));

  extremum_track #(.WIDTH(WIDTH), .MODE(EXT_MAX)) u_max (
    .clk(clk), .rst_n(rst_n), .clr(clr), .restart(neg_ev), .datain(datain), .ext(max_now)
  );

  extremum_track #(.WIDTH(WIDTH), .MODE(EXT_MIN)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(clr), .restart(min_restart), .datain(datain), .ext(min_now)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: the first peak arms the meter; it stays armed until clear.
  always_comb begin
    state_nxt = state;
    if (state == IDLE && posen) state_nxt = ARMED;
  end

  // FSM outputs: arming, record emission, and min-tracker restart on real peaks.
  always_comb begin
    arm         = (state == IDLE) && posen;
    rec_fire    = (state == ARMED) && posen && !noise && valley_seen;
    min_restart = posen && !noise;
  end

  // Latch the valley on each valley pulse; a real peak consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valley_q    <= '0;
      valley_seen <= 1'b0;
    end else if (clr) begin
      valley_q    <= '0;
      valley_seen <= 1'b0;
    end else if (neg_ev) begin
      valley_q    <= min_now;
      valley_seen <= 1'b1;
    end else if (min_restart) begin
      valley_seen <= 1'b0;
    end
  end

  // Peak-to-peak counter: restarts at 1 on arming or on each emitted record,
  // otherwise counts up and sticks at the ceiling with sat_q set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      sat_q <= 1'b0;
    end else if (arm || rec_fire) begin
      cnt   <= CNT_WIDTH'(1);
      sat_q <= 1'b0;
    end else if (state == ARMED) begin
      if (cnt == CNT_TOP) sat_q <= 1'b1;
      else                cnt   <= cnt + 1'b1;
    end
  end

  assign rec_new = '{period: cnt, peak: max_now, valley: valley_q, period_sat: sat_q};

  // Output register: load when free or being drained, otherwise drop and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rec_q     <= '0;
      overrun   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      rec_q     <= '0;
      overrun   <= 1'b0;
    end else if (rec_fire) begin
      if (!out_valid || out_ready) begin
        rec_q     <= rec_new;
        out_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign period     = rec_q.period;
  assign peak       = rec_q.peak;
  assign valley     = rec_q.valley;
  assign period_sat = rec_q.period_sat;

endmodule

// File: tb/tb_slope_period_meter.sv
// Self-checking bench for slope_period_meter: table-driven triangle run,
// scoreboard of expected records, and hand sequences for the corner cases.
module tb_slope_period_meter;

  typedef struct packed {
    logic [23:0] per;
    logic [15:0] pk;
    logic [15:0] vl;
    logic        sat;
  } rec_t;

  typedef struct {
    logic [15:0] d;
    logic        p;
    logic        n;
    logic        push;
    logic        e_valid;
    rec_t        e_rec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic [15:0] datain;
  logic        posen, negen, out_ready;
  logic        out_valid, period_sat, overrun;
  logic [23:0] period;
  logic [15:0] peak, valley;

  logic [15:0] s_datain;
  logic        s_posen, s_negen, s_ready;
  logic        s_valid, s_sat, s_overrun;
  logic [3:0]  s_period;
  logic [15:0] s_peak, s_valley;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t exp_q[$];
  vec_t tbl[76];

  always #5 clk = ~clk;

  slope_period_meter u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .datain(datain), .posen(posen), .negen(negen),
    .out_valid(out_valid), .out_ready(out_ready), .period(period), .peak(peak),
    .valley(valley), .period_sat(period_sat), .overrun(overrun)
  );

  slope_period_meter #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .datain(s_datain), .posen(s_posen), .negen(s_negen),
    .out_valid(s_valid), .out_ready(s_ready), .period(s_period), .peak(s_peak),
    .valley(s_valley), .period_sat(s_sat), .overrun(s_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [15:0] d, input logic p, input logic n);
    datain = d; posen = p; negen = n;
    tick();
    posen = 1'b0; negen = 1'b0;
  endtask

  task automatic s_cyc(input logic [15:0] d, input logic p, input logic n);
    s_datain = d; s_posen = p; s_negen = n;
    tick();
    s_posen = 1'b0; s_negen = 1'b0;
  endtask

  task automatic tri_cycle(input logic neg0);
    for (int t = 0; t < 20; t++)
      cyc(16'((t <= 10) ? t : 20 - t), t == 10, (t == 0) && neg0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic push(input int per, input int pk, input int vl, input logic sat);
    exp_q.push_back('{per: 24'(per), pk: 16'(pk), vl: 16'(vl), sat: sat});
  endtask

  // Scoreboard: every accepted record must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_record: got period %0d peak %0d valley %0d, expected none",
                 period, peak, valley);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rec_period", 32'(period), 32'(e.per));
        chk("rec_peak", 32'(peak), 32'(e.pk));
        chk("rec_valley", 32'(valley), 32'(e.vl));
        chk("rec_sat", 32'(period_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; datain = '0; posen = 1'b0; negen = 1'b0; out_ready = 1'b1;
    s_datain = '0; s_posen = 1'b0; s_negen = 1'b0; s_ready = 1'b1;

    for (int i = 0; i < 76; i++) begin
      int ph;
      ph = i % 20;
      tbl[i].d       = 16'((ph <= 10) ? ph : 20 - ph);
      tbl[i].p       = (ph == 10);
      tbl[i].n       = (ph == 0) && (i > 0);
      tbl[i].push    = (ph == 10) && (i > 10);
      tbl[i].e_valid = tbl[i].push;
      tbl[i].e_rec   = '{per: 24'd20, pk: 16'd10, vl: 16'd0, sat: 1'b0};
    end

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_peak", 32'(peak), 0);
    chk("rst_valley", 32'(valley), 0);
    chk("rst_sat", 32'(period_sat), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_s_valid", 32'(s_valid), 0);
    rst_n = 1'b1;
    tick();

    // 1: triangle 0..10..0, first peak arms only
    for (int i = 0; i < 76; i++) begin
      if (tbl[i].push) exp_q.push_back(tbl[i].e_rec);
      cyc(tbl[i].d, tbl[i].p, tbl[i].n);
      chk($sformatf("tri_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].e_valid));
    end

    // 2: consumer stalled across two peaks
    do_clr();
    out_ready = 1'b0;
    tri_cycle(1'b0);
    push(20, 10, 0, 1'b0);
    tri_cycle(1'b1);
    tri_cycle(1'b1);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_period", 32'(period), 20);
    chk("stall_peak", 32'(peak), 10);
    chk("stall_valley", 32'(valley), 0);
    chk("stall_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("overrun_sticky", 32'(overrun), 1);
    do_clr();
    chk("clr_overrun", 32'(overrun), 0);
    chk("clr_valid", 32'(out_valid), 0);

    // 3: 4-bit counter saturates, then recovers
    s_cyc(16'd50, 1'b1, 1'b0);
    repeat (19) s_cyc(16'd20, 1'b0, 1'b0);
    s_cyc(16'd1, 1'b0, 1'b1);
    repeat (19) s_cyc(16'd20, 1'b0, 1'b0);
    s_cyc(16'd60, 1'b1, 1'b0);
    chk("sat_valid", 32'(s_valid), 1);
    chk("sat_period", 32'(s_period), 15);
    chk("sat_flag", 32'(s_sat), 1);
    chk("sat_peak", 32'(s_peak), 60);
    chk("sat_valley", 32'(s_valley), 1);
    repeat (3) s_cyc(16'd20, 1'b0, 1'b0);
    s_cyc(16'd2, 1'b0, 1'b1);
    repeat (3) s_cyc(16'd20, 1'b0, 1'b0);
    s_cyc(16'd30, 1'b1, 1'b0);
    chk("unsat_period", 32'(s_period), 8);
    chk("unsat_flag", 32'(s_sat), 0);

    // 4: simultaneous posen/negen acts as a peak only
    do_clr();
    cyc(16'd10, 1'b1, 1'b0);
    for (int v = 9; v >= 3; v--) cyc(16'(v), 1'b0, 1'b0);
    cyc(16'd2, 1'b0, 1'b1);
    for (int v = 3; v <= 6; v++) cyc(16'(v), 1'b0, 1'b0);
    push(13, 7, 2, 1'b0);
    cyc(16'd7, 1'b1, 1'b1);
    chk("both_valid", 32'(out_valid), 1);
    cyc(16'd8, 1'b0, 1'b0);
    cyc(16'd9, 1'b1, 1'b0);
    chk("both_no_valley", 32'(out_valid), 0);
    cyc(16'd6, 1'b0, 1'b0);
    cyc(16'd4, 1'b0, 1'b1);
    push(5, 8, 4, 1'b0);
    cyc(16'd8, 1'b1, 1'b0);
    chk("both_next_valid", 32'(out_valid), 1);

    // 5: async reset with a record pending
    do_clr();
    out_ready = 1'b0;
    cyc(16'd10, 1'b1, 1'b0);
    cyc(16'd5, 1'b0, 1'b1);
    cyc(16'd9, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_peak", 32'(peak), 0);
    tick();
    rst_n = 1'b1;
    cyc(16'd3, 1'b0, 1'b1);
    cyc(16'd10, 1'b1, 1'b0);
    chk("post_rst_idle", 32'(out_valid), 0);
    out_ready = 1'b1;
    cyc(16'd2, 1'b0, 1'b1);
    push(2, 10, 2, 1'b0);
    cyc(16'd10, 1'b1, 1'b0);
    chk("post_rst_rec", 32'(out_valid), 1);

    // 6: small ripple between large peaks
    do_clr();
    cyc(16'd100, 1'b1, 1'b0);
    cyc(16'd50, 1'b0, 1'b0);
    cyc(16'd5, 1'b0, 1'b1);
`ifdef SPM_HYST_EN
    cyc(16'd7, 1'b1, 1'b0);
    chk("ripple_suppressed", 32'(out_valid), 0);
    cyc(16'd5, 1'b0, 1'b1);
    cyc(16'd0, 1'b0, 1'b1);
    push(6, 100, 0, 1'b0);
    cyc(16'd100, 1'b1, 1'b0);
`else
    push(3, 7, 5, 1'b0);
    cyc(16'd7, 1'b1, 1'b0);
    chk("ripple_rec", 32'(out_valid), 1);
    cyc(16'd5, 1'b0, 1'b1);
    cyc(16'd0, 1'b0, 1'b1);
    push(3, 100, 0, 1'b0);
    cyc(16'd100, 1'b1, 1'b0);
`endif
    chk("big_peak_valid", 32'(out_valid), 1);
    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
